// File: rtl/beat_timer.sv
// Tempo-scaled note-duration timer: times one note in 1/16-beat ticks derived from bpm.
// Define ARTIC_GAP_EN for a staccato gap: note_gate drops during the final tick period.
module beat_timer #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BPM_W  = 8
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [BPM_W-1:0] i_bpm,
    input  logic             i_pause,
    input  logic             i_note_valid,
    output logic             o_note_ready,
    input  logic [3:0]       i_note_code,
    input  logic             i_note_dot,
    input  logic             i_note_rest,
    output logic             o_note_gate,
    output logic             o_beat_finish,
    output logic             o_tick
);

    // state | meaning
    // IDLE  | waiting for a note, note_ready high
    // PLAY  | timing the accepted note
    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

    // 64-bit math: CLK_HZ*60 overflows 32 bits at the default clock rate
    localparam longint TICK_DEN = (longint'(CLK_HZ) * 60) / 16;
    localparam int ACC_W = $clog2(TICK_DEN + (longint'(1) << BPM_W));
    localparam logic [ACC_W-1:0] TICK_DEN_V = TICK_DEN[ACC_W-1:0];

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [6:0]       r_count;
    logic [6:0]       r_len;
    logic             r_rest;
    logic             r_gate;
    logic             r_finish;

    logic [ACC_W-1:0] w_sum;
    logic             w_tick;
    logic             w_last;
    logic             w_accept;
    logic             w_gate_drop;
    logic [6:0]       w_base_len;
    logic [6:0]       w_len_sel;

    function automatic logic [6:0] base_len(input logic [3:0] code);
        case (code)
            4'd1:    base_len = 7'd64;
            4'd2:    base_len = 7'd32;
            4'd3:    base_len = 7'd16;
            4'd4:    base_len = 7'd8;
            4'd5:    base_len = 7'd4;
            4'd6:    base_len = 7'd2;
            default: base_len = 7'd8;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_sum       = r_acc + ACC_W'(i_bpm);
        w_tick      = (r_state == PLAY) && !i_pause && (w_sum >= TICK_DEN_V);
        w_last      = w_tick && (r_count == r_len - 7'd1);
        w_accept    = (r_state == IDLE) && i_note_valid;
        w_base_len  = base_len(i_note_code);
        w_len_sel   = i_note_dot ? (w_base_len + (w_base_len >> 1)) : w_base_len;
`ifdef ARTIC_GAP_EN
        w_gate_drop = w_tick && (r_count == r_len - 7'd2);
`else
        w_gate_drop = 1'b0;
`endif
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = PLAY;
            PLAY:    if (w_last)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_count  <= '0;
            r_len    <= '0;
            r_rest   <= 1'b0;
            r_gate   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_finish <= w_last;
            if (w_accept) begin
                r_len   <= w_len_sel;
                r_rest  <= i_note_rest;
                r_acc   <= '0;
                r_count <= '0;
                r_gate  <= !i_note_rest;
            end else if (r_state == PLAY) begin
                if (!i_pause) begin
                    r_acc <= w_tick ? (w_sum - TICK_DEN_V) : w_sum;
                end
                if (w_tick) begin
                    r_count <= r_count + 7'd1;
                end
                if (w_last || w_gate_drop) begin
                    r_gate <= 1'b0;
                end
            end
        end
    end

    assign o_note_ready  = (r_state == IDLE);
    assign o_note_gate   = r_gate;
    assign o_beat_finish = r_finish;
    assign o_tick        = w_tick;

endmodule

// File: tb/tb_beat_timer.sv
// Directed bench for beat_timer at CLK_HZ=16 (TICK_DEN=60); expected timings hand-computed.
module tb_beat_timer;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] bpm;
    logic       pause;
    logic       note_valid;
    logic       note_ready;
    logic [3:0] note_code;
    logic       note_dot;
    logic       note_rest;
    logic       note_gate;
    logic       beat_finish;
    logic       tick;

    int n_checks = 0;
    int n_errors = 0;

    beat_timer #(.CLK_HZ(16), .BPM_W(8)) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_bpm         (bpm),
        .i_pause       (pause),
        .i_note_valid  (note_valid),
        .o_note_ready  (note_ready),
        .i_note_code   (note_code),
        .i_note_dot    (note_dot),
        .i_note_rest   (note_rest),
        .o_note_gate   (note_gate),
        .o_beat_finish (beat_finish),
        .o_tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept a note at the next edge, then watch until beat_finish (cycle 1 = first PLAY cycle).
    task automatic run_note(input string tag, input logic [7:0] b, input logic [3:0] code,
                            input logic dot, input logic rest, input int p_start, input int p_len,
                            input int exp_fin, input int exp_gate, input int exp_ticks);
        int  cyc;
        int  gate_n;
        int  tick_n;
        int  ready_in_play;
        bit  seen;
        bpm        = b;
        note_code  = code;
        note_dot   = dot;
        note_rest  = rest;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        cyc = 1; gate_n = 0; tick_n = 0; ready_in_play = 0; seen = 0;
        while (!seen && cyc < 400) begin
            pause = (cyc >= p_start) && (cyc < p_start + p_len);
            #1;
            if (beat_finish) begin
                seen = 1;
            end else begin
                gate_n        += int'(note_gate);
                tick_n        += int'(tick);
                ready_in_play += int'(note_ready);
                step();
                cyc++;
            end
        end
        pause = 1'b0;
        chk({tag, " finish_cycle"}, cyc, exp_fin);
        chk({tag, " gate_cycles"}, gate_n, exp_gate);
        chk({tag, " ticks"}, tick_n, exp_ticks);
        chk({tag, " ready_in_play"}, ready_in_play, 0);
        chk({tag, " ready_at_finish"}, int'(note_ready), 1);
        chk({tag, " gate_at_finish"}, int'(note_gate), 0);
        step();
        chk({tag, " finish_one_cycle"}, int'(beat_finish), 0);
    endtask

    initial begin
        int fin_seen;
        rstn = 1'b0; bpm = 8'd60; pause = 1'b0; note_valid = 1'b0;
        note_code = 4'd3; note_dot = 1'b0; note_rest = 1'b0;
        step();
        step();
        chk("reset ready", int'(note_ready), 1);
        chk("reset gate", int'(note_gate), 0);
        chk("reset finish", int'(beat_finish), 0);
        chk("reset tick", int'(tick), 0);
        rstn = 1'b1;
        step();

        run_note("q16_bpm60", 8'd60, 4'd3, 1'b0, 1'b0, 0, 0, 17, 16, 16);
        run_note("dot2_bpm30", 8'd30, 4'd6, 1'b1, 1'b0, 0, 0, 7, 6, 3);
        run_note("rest4_bpm60", 8'd60, 4'd5, 1'b0, 1'b1, 0, 0, 5, 0, 4);
        run_note("whole_pause10", 8'd60, 4'd1, 1'b0, 1'b0, 20, 10, 75, 74, 64);
        run_note("dot_whole96", 8'd60, 4'd1, 1'b1, 1'b0, 0, 0, 97, 96, 96);
        run_note("codeF_is8", 8'd60, 4'hF, 1'b0, 1'b0, 0, 0, 9, 8, 8);
        run_note("rem_bpm45", 8'd45, 4'd6, 1'b0, 1'b0, 0, 0, 4, 3, 2);
        run_note("accclr_bpm50", 8'd50, 4'd6, 1'b0, 1'b0, 0, 0, 4, 3, 2);
`ifdef ARTIC_GAP_EN
        run_note("artic_bpm30", 8'd30, 4'd4, 1'b0, 1'b0, 0, 0, 17, 14, 8);
`else
        run_note("legato_bpm30", 8'd30, 4'd4, 1'b0, 1'b0, 0, 0, 17, 16, 8);
`endif

        // Reset during PLAY cycle 5: note aborts with no beat_finish.
        bpm = 8'd60; note_code = 4'd3; note_dot = 1'b0; note_rest = 1'b0;
        note_valid = 1'b1;
        step();
        note_valid = 1'b0;
        repeat (4) step();
        chk("pre_reset gate", int'(note_gate), 1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("midreset ready", int'(note_ready), 1);
        chk("midreset gate", int'(note_gate), 0);
        chk("midreset tick", int'(tick), 0);
        fin_seen = 0;
        for (int i = 0; i < 20; i++) begin
            fin_seen += int'(beat_finish);
            step();
        end
        chk("midreset no_finish", fin_seen, 0);
        run_note("after_reset", 8'd60, 4'd5, 1'b0, 1'b0, 0, 0, 5, 4, 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
